// File: rtl/drum_pipe.sv
// ---------------------------------------------------------------------------
// drum_pipe: pipelined DRUM approximate multiplier with signed/unsigned mode.
//
// Each operand is reduced to a K-bit mantissa (leading one, K-2 following
// bits, forced trailing one) plus a shift. The mantissas are multiplied exactly
// and the product is shifted back. Operands below 2^K bypass the approximation.
// Signed beats are handled as sign/magnitude, so the error is symmetric.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  operand beat handshake
//   in_signed       1 = operands are two's complement, 0 = unsigned
//   in_a [N], in_b [M], in_tag [TAG_W]   operands and user tag
//   out_valid/ready result handshake
//   out_r [N+M]     approximate product, out_tag [TAG_W] tag of that beat
//   busy            any pipeline stage holds a valid beat
//
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// The source must hold its beat stable while valid & !ready. out_r and out_tag
// stay stable while out_valid & !out_ready. in_ready does not depend on
// in_valid.
// ---------------------------------------------------------------------------
module drum_pipe #(
    parameter int K     = 4,
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [N-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int L   = (N > M) ? N : M;
    localparam int SW  = $clog2(L + 1);
    localparam int SHW = SW + 1;
    localparam int RW  = N + M;

    typedef struct packed {
        logic [K-1:0]  mant;
        logic [SW-1:0] shift;
    } enc_t;

    // DRUM encoding of one magnitude. p is the leading-one position; values
    // with p < K (including zero) are kept exactly with no shift.
    function automatic enc_t drum_enc(input logic [L-1:0] x);
        enc_t e;
        int   p;
        p = 0;
        for (int i = 0; i < L; i++) begin
            if (x[i]) p = i;
        end
        e.mant  = x[K-1:0];
        e.shift = '0;
        if (p >= K) begin
            // Right-aligning puts the leading one at bit K-1; bit 0 is forced
            // to 1 to centre the truncation error.
            e.mant  = K'(x >> (p - (K - 1))) | K'(1);
            e.shift = SW'(p - (K - 1));
        end
        return e;
    endfunction

    // Stage 1: sign/magnitude
    logic             s1_v_q,   s1_v_d;
    logic [N-1:0]     s1_ma_q,  s1_ma_d;
    logic [M-1:0]     s1_mb_q,  s1_mb_d;
    logic             s1_so_q,  s1_so_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    // Stage 2: DRUM encode
    logic             s2_v_q,   s2_v_d;
    logic [K-1:0]     s2_mant_a_q, s2_mant_a_d;
    logic [K-1:0]     s2_mant_b_q, s2_mant_b_d;
    logic [SHW-1:0]   s2_sh_q,  s2_sh_d;
    logic             s2_so_q,  s2_so_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    // Stage 3: product, drives the outputs
    logic             s3_v_q,   s3_v_d;
    logic [RW-1:0]    s3_r_q,   s3_r_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;

    logic          adv;
    logic          accept;
    enc_t          enc_a, enc_b;
    logic [RW-1:0] prod;

    always_comb begin
        // Global stall: the whole pipe moves only when the output slot frees.
        adv    = !s3_v_q | out_ready;
        accept = in_valid & adv;

        enc_a = drum_enc(L'(s1_ma_q));
        enc_b = drum_enc(L'(s1_mb_q));
        prod  = (RW'(s2_mant_a_q) * RW'(s2_mant_b_q)) << s2_sh_q;

        s1_v_d      = s1_v_q;
        s1_ma_d     = s1_ma_q;
        s1_mb_d     = s1_mb_q;
        s1_so_d     = s1_so_q;
        s1_tag_d    = s1_tag_q;
        s2_v_d      = s2_v_q;
        s2_mant_a_d = s2_mant_a_q;
        s2_mant_b_d = s2_mant_b_q;
        s2_sh_d     = s2_sh_q;
        s2_so_d     = s2_so_q;
        s2_tag_d    = s2_tag_q;
        s3_v_d      = s3_v_q;
        s3_r_d      = s3_r_q;
        s3_tag_d    = s3_tag_q;

        if (adv) begin
            s1_v_d = accept;
            s2_v_d = s1_v_q;
            s3_v_d = s2_v_q;

            // Data registers load only behind a valid beat, so bubbles leave
            // the last result visible and save toggling.
            if (accept) begin
                // Negation of the most negative value wraps to 2^(W-1), which
                // is the correct unsigned magnitude.
                s1_ma_d  = (in_signed && in_a[N-1]) ? (~in_a + N'(1)) : in_a;
                s1_mb_d  = (in_signed && in_b[M-1]) ? (~in_b + M'(1)) : in_b;
                s1_so_d  = in_signed & (in_a[N-1] ^ in_b[M-1]);
                s1_tag_d = in_tag;
            end
            if (s1_v_q) begin
                s2_mant_a_d = enc_a.mant;
                s2_mant_b_d = enc_b.mant;
                s2_sh_d     = SHW'(enc_a.shift) + SHW'(enc_b.shift);
                s2_so_d     = s1_so_q;
                s2_tag_d    = s1_tag_q;
            end
            if (s2_v_q) begin
                // A zero product stays zero rather than becoming -0.
                s3_r_d   = (s2_so_q && (prod != '0)) ? (~prod + RW'(1)) : prod;
                s3_tag_d = s2_tag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_so_q     <= 1'b0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_mant_a_q <= '0;
            s2_mant_b_q <= '0;
            s2_sh_q     <= '0;
            s2_so_q     <= 1'b0;
            s2_tag_q    <= '0;
            s3_v_q      <= 1'b0;
            s3_r_q      <= '0;
            s3_tag_q    <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s1_so_q     <= s1_so_d;
            s1_tag_q    <= s1_tag_d;
            s2_v_q      <= s2_v_d;
            s2_mant_a_q <= s2_mant_a_d;
            s2_mant_b_q <= s2_mant_b_d;
            s2_sh_q     <= s2_sh_d;
            s2_so_q     <= s2_so_d;
            s2_tag_q    <= s2_tag_d;
            s3_v_q      <= s3_v_d;
            s3_r_q      <= s3_r_d;
            s3_tag_q    <= s3_tag_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = s3_v_q;
    assign out_r     = s3_r_q;
    assign out_tag   = s3_tag_q;
    assign busy      = s1_v_q | s2_v_q | s3_v_q;

endmodule

// File: tb/tb_drum_pipe.sv
// ---------------------------------------------------------------------------
// tb_drum_pipe: directed bench for drum_pipe with K=4, N=M=8, TAG_W=4.
// Expected products are hand-computed DRUM results.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_drum_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_r;
    logic [3:0]  out_tag;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  exp_tag_q[$];

    // Back-to-back vector table: a, b, signed, expected product
    logic [7:0]  bb_a [8] = '{8'd200, 8'd13, 8'd255, 8'd16, 8'd15, 8'hC8, 8'h80, 8'h00};
    logic [7:0]  bb_b [8] = '{8'd3,   8'd11, 8'd255, 8'd16, 8'd15, 8'd3,  8'h80, 8'h80};
    logic        bb_s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] bb_r [8] = '{16'd624, 16'd143, 16'hE100, 16'd324, 16'd225,
                              16'hFF4C, 16'h5100, 16'h0000};

    drum_pipe #(.K(4), .N(8), .M(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one beat for one edge; entered just after a rising edge while
    // in_ready is 1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [3:0] tag);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    // Waits on falling edges for out_valid; lat counts falling edges.
    task automatic wait_result(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (out_r !== 16'h0000) begin n_fail++; $display("FAIL reset_out_r got=%h want=0000", out_r); end
        n_cmp++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_unsigned();
        bit got; int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(8'd200, 8'd3, 1'b0, 4'd5);
        wait_result(got, lat);
        n_cmp++; if (!got) begin n_fail++; $display("FAIL unsigned_timeout got=no_result want=result"); end
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL unsigned_latency got=%0d want=3", lat); end
        n_cmp++; if (out_r !== 16'd624) begin n_fail++; $display("FAIL unsigned_r got=%0d want=624", out_r); end
        n_cmp++; if (out_tag !== 4'd5) begin n_fail++; $display("FAIL unsigned_tag got=%0d want=5", out_tag); end
    endtask

    task automatic test_exact();
        bit got; int lat;
        @(posedge clk); #1;
        issue(8'd13, 8'd11, 1'b0, 4'd9);
        wait_result(got, lat);
        n_cmp++; if (!got) begin n_fail++; $display("FAIL exact_timeout got=no_result want=result"); end
        n_cmp++; if (out_r !== 16'd143) begin n_fail++; $display("FAIL exact_r got=%0d want=143", out_r); end
        n_cmp++; if (out_tag !== 4'd9) begin n_fail++; $display("FAIL exact_tag got=%0d want=9", out_tag); end
        // Swapped operands of the approximate case
        @(posedge clk); #1;
        issue(8'd3, 8'd200, 1'b0, 4'd4);
        wait_result(got, lat);
        n_cmp++; if (!got) begin n_fail++; $display("FAIL swap_timeout got=no_result want=result"); end
        n_cmp++; if (out_r !== 16'd624) begin n_fail++; $display("FAIL swap_r got=%0d want=624", out_r); end
    endtask

    task automatic test_signed();
        logic [7:0]  ta [4] = '{8'hC8, 8'h80, 8'h00, 8'hFF};
        logic [7:0]  tb [4] = '{8'h03, 8'h80, 8'h80, 8'h05};
        logic [15:0] tr [4] = '{16'hFF4C, 16'h5100, 16'h0000, 16'hFFFB};
        bit got; int lat;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            issue(ta[i], tb[i], 1'b1, 4'(i + 10));
            wait_result(got, lat);
            n_cmp++; if (!got) begin n_fail++; $display("FAIL signed_timeout[%0d] got=no_result want=result", i); end
            n_cmp++; if (out_r !== tr[i]) begin n_fail++; $display("FAIL signed_r[%0d] got=%h want=%h", i, out_r, tr[i]); end
            n_cmp++; if (out_tag !== 4'(i + 10)) begin n_fail++; $display("FAIL signed_tag[%0d] got=%0d want=%0d", i, out_tag, i + 10); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        logic [15:0] er;
        logic [3:0]  et;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                in_valid  = 1'b1;
                in_a      = bb_a[c];
                in_b      = bb_b[c];
                in_signed = bb_s[c];
                in_tag    = 4'(c + 3);
                exp_q.push_back(bb_r[c]);
                exp_tag_q.push_back(4'(c + 3));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", c, in_ready); end
            exp_v = (c >= 3 && c <= 10);
            n_cmp++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL b2b_out_valid[%0d] got=%b want=%b", c, out_valid, exp_v); end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra[%0d] got=result want=none", c);
                end else begin
                    er = exp_q.pop_front();
                    et = exp_tag_q.pop_front();
                    if (out_r !== er) begin n_fail++; $display("FAIL b2b_r[%0d] got=%h want=%h", c, out_r, er); end
                    n_cmp++; if (out_tag !== et) begin n_fail++; $display("FAIL b2b_tag[%0d] got=%0d want=%0d", c, out_tag, et); end
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing got=%0d_left want=0", exp_q.size()); end
        exp_q.delete();
        exp_tag_q.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] er [3] = '{16'd624, 16'd143, 16'hFF4C};
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 8'd200; in_b = 8'd3;  in_signed = 1'b0; in_tag = 4'd1;
        @(posedge clk); #1;
        in_a = 8'd13;  in_b = 8'd11; in_signed = 1'b0; in_tag = 4'd2;
        @(posedge clk); #1;
        in_a = 8'hC8;  in_b = 8'd3;  in_signed = 1'b1; in_tag = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (out_tag !== 4'd1) begin n_fail++; $display("FAIL bp_tag_hold[%0d] got=%0d want=1", i, out_tag); end
            n_cmp++; if (out_r !== 16'd624) begin n_fail++; $display("FAIL bp_r_hold[%0d] got=%0d want=624", i, out_r); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d] got=%b want=1", i, busy); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (out_tag !== 4'(i + 1)) begin n_fail++; $display("FAIL bp_drain_tag[%0d] got=%0d want=%0d", i, out_tag, i + 1); end
            n_cmp++; if (out_r !== er[i]) begin n_fail++; $display("FAIL bp_drain_r[%0d] got=%h want=%h", i, out_r, er[i]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid got=%b want=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_end_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_midflight();
        bit got; int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 8'd200; in_b = 8'd3; in_signed = 1'b0; in_tag = 4'd6;
        @(posedge clk); #1;
        in_a = 8'd13; in_b = 8'd11; in_tag = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmf_busy_before got=%b want=1", busy); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy got=%b want=0", busy); end
        n_cmp++; if (out_r !== 16'h0000) begin n_fail++; $display("FAIL rmf_out_r got=%h want=0000", out_r); end
        n_cmp++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL rmf_out_tag got=%h want=0", out_tag); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_stale[%0d] got=%b want=0", i, out_valid); end
        end
        @(posedge clk); #1;
        issue(8'd5, 8'd7, 1'b0, 4'd2);
        wait_result(got, lat);
        n_cmp++; if (!got) begin n_fail++; $display("FAIL rmf_new_timeout got=no_result want=result"); end
        n_cmp++; if (out_r !== 16'd35) begin n_fail++; $display("FAIL rmf_new_r got=%0d want=35", out_r); end
        n_cmp++; if (out_tag !== 4'd2) begin n_fail++; $display("FAIL rmf_new_tag got=%0d want=2", out_tag); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_exact();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
